// File: rtl/ifu_fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_fetch_pkg;

  localparam int          INST_W       = 32;
  localparam int          ADDR_W       = 64;
  localparam int          ENT_W        = ADDR_W + INST_W;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  // IDLE: free to issue; WAIT: one request outstanding; DROP: outstanding
  // response belongs to a squashed path and must be discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Purpose: small {pc,inst} FIFO between the memory response and the core.
// Latency: write in cycle N is visible at the head in cycle N+1.
// Backpressure: none internally; the writer must only push when a slot frees.
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [ENT_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [ENT_W-1:0] head_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // A flush overrides both push and pop in the same cycle.
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (cnt_q != '0);

  // Storage is zeroed on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/ifu_fetch.sv
// Purpose: fetch PC owner; one outstanding imem read, buffered {pc,inst} to core, redirect flush.
// Latency: response in cycle N -> inst_valid in N+1; redirect in N -> new request in N+1 (or after a dropped response).
// Backpressure: requests held until imem_req_ready; issue stops when the FIFO has no slot. IFU_PERF_EN adds perf counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_e state_q, state_d;
  logic [63:0]  fpc_q, fpc_d;
  logic [63:0]  pend_pc_q, pend_pc_d;

  logic          req_vld;
  logic          req_acc;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW:0]   occ_after;
  logic          room_after;
  fetch_ent_t    push_ent;
  fetch_ent_t    head_ent;

  assign pop        = inst_valid & inst_ready;
  // Occupancy once this cycle's response is written and any pop retires.
  assign occ_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign room_after = occ_after < (CW+1)'(DEPTH);
  assign push_ent   = '{pc: pend_pc_q, inst: imem_resp_data};

  // Issue, push and next-state decisions; redirect suppresses all activity.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    pend_pc_d = pend_pc_q;
    req_vld   = 1'b0;
    push      = 1'b0;

    if (!rst && !redirect_valid) begin
      unique case (state_q)
        ST_IDLE: req_vld = !fifo_full;
        ST_WAIT: req_vld = imem_resp_valid && room_after;
        default: req_vld = 1'b0;
      endcase
    end
    req_acc = req_vld && imem_req_ready;
    push    = !rst && !redirect_valid && (state_q == ST_WAIT) && imem_resp_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid)  state_d = ST_IDLE;
        else if (req_acc)    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid)       state_d = imem_resp_valid ? ST_IDLE : ST_DROP;
        else if (imem_resp_valid) state_d = req_acc ? ST_WAIT : ST_IDLE;
      end
      ST_DROP: begin
        if (imem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      fpc_d = redirect_pc;
    end else if (req_acc) begin
      fpc_d     = fpc_q + 64'd4;
      pend_pc_d = fpc_q;
    end
  end

  // Fetch PC, pending PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fpc_q     <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  ifu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .count_o    (count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = fpc_q;
  assign inst_valid     = !rst && !fifo_empty;
  assign inst           = rst ? '0 : head_ent.inst;
  assign inst_pc        = rst ? '0 : head_ent.pc;

`ifdef IFU_PERF_EN
  // Event counters survive redirects and wrap silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 64'(push);
      perf_stall_cnt <= perf_stall_cnt + 64'(inst_ready && !inst_valid);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Purpose: directed scoreboard bench for ifu_fetch with a behavioural instruction memory.
// Latency: memory answers mem_lat cycles after accepting a request.
// Backpressure: imem_req_ready and inst_ready are driven per test.
module tb_ifu_fetch;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_req[$];
  ent_t        exp_inst[$];

  int          mem_lat;
  logic        m_pend;
  int          m_cnt;
  logic [63:0] m_addr;

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion required completion");
    $fatal(1);
  end

  // addi x1, x0, <word index>: word at 0x80000004 is 0x00100093.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[13:2], 20'h00093};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic wait_acc(input string name, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic end_chk(input string pfx);
    chk({pfx, "_req_left"},  64'(exp_req.size()),  64'd0);
    chk({pfx, "_inst_left"}, 64'(exp_inst.size()), 64'd0);
  endtask

  // Leaves the bench at the start of the first cycle with rst low.
  task automatic do_reset(input string pfx, input logic rdy, input logic irdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    drain(2);
    @(negedge clk);
    chk({pfx, "_rst_req_valid"},  64'(imem_req_valid), 64'd0);
    chk({pfx, "_rst_inst_valid"}, 64'(inst_valid),     64'd0);
    chk({pfx, "_rst_inst"},       64'(inst),           64'd0);
    chk({pfx, "_rst_inst_pc"},    inst_pc,             64'd0);
    step();
    rst = 1'b0;
  endtask

  // Behavioural memory: one outstanding read, answered mem_lat cycles later.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_pend && m_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(m_addr);
        m_pend          = 1'b0;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (m_pend) m_cnt--;
      end
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        m_pend = 1'b1;
        m_cnt  = mem_lat;
        m_addr = imem_req_addr;
      end
    end
  end

  // Monitor: checks every accepted request and every consumed instruction.
  initial begin
    ent_t e;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h required no request", imem_req_addr);
        end else begin
          a = exp_req.pop_front();
          chk("req_addr", imem_req_addr, a);
        end
      end
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_inst.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL inst_unexpected: got pc %h inst %h required none", inst_pc, inst);
        end else begin
          e = exp_inst.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst",    64'(inst), 64'(e.w));
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;

    // A: single-cycle memory, full throughput.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    exp_inst.push_back('{pc: 64'h8000_0000, w: 32'h0000_0093});
    exp_inst.push_back('{pc: 64'h8000_0004, w: 32'h0010_0093});
    exp_inst.push_back('{pc: 64'h8000_0008, w: 32'h0020_0093});
    do_reset("a", 1'b1, 1'b1);
    @(negedge clk);
    chk("a_first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("a_first_req_addr",  imem_req_addr,        64'h8000_0000);
    step();
    step();
    @(negedge clk);
    chk("a_inst_valid_c2", 64'(inst_valid), 64'd1);
    step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("a_inst_valid_c3", 64'(inst_valid),     64'd1);
    chk("a_req_valid_c3",  64'(imem_req_valid), 64'd1);
    chk("a_req_addr_c3",   imem_req_addr,       64'h8000_000C);
    step();
    @(negedge clk);
    chk("a_inst_valid_c4", 64'(inst_valid), 64'd1);
    drain(4);
    end_chk("a");

    // B: request held stable while memory is not ready.
    exp_req.push_back(64'h8000_0000);
    exp_inst.push_back('{pc: 64'h8000_0000, w: 32'h0000_0093});
    do_reset("b", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 64'(imem_req_valid), 64'd1);
      chk("b_hold_addr",  imem_req_addr,       64'h8000_0000);
      step();
    end
    imem_req_ready = 1'b1;
    wait_acc("b_acc", 2);
    step();
    imem_req_ready = 1'b0;
    drain(4);
    end_chk("b");

    // C: core stalled, FIFO fills, fetch resumes at 0x80000008.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    exp_inst.push_back('{pc: 64'h8000_0000, w: 32'h0000_0093});
    exp_inst.push_back('{pc: 64'h8000_0004, w: 32'h0010_0093});
    exp_inst.push_back('{pc: 64'h8000_0008, w: 32'h0020_0093});
    do_reset("c", 1'b1, 1'b0);
    drain(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("c_full_no_req",   64'(imem_req_valid), 64'd0);
      chk("c_full_inst_vld", 64'(inst_valid),     64'd1);
      step();
    end
    inst_ready = 1'b1;
    wait_acc("c_resume_acc", 8);
    step();
    imem_req_ready = 1'b0;
    drain(4);
    end_chk("c");

    // D: redirect while the request to 0x80000004 is outstanding.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0100);
    exp_inst.push_back('{pc: 64'h8000_0000, w: 32'h0000_0093});
    exp_inst.push_back('{pc: 64'h8000_0100, w: 32'h0400_0093});
    mem_lat = 3;
    do_reset("d", 1'b1, 1'b1);
    wait_acc("d_acc0", 2);
    wait_acc("d_acc1", 6);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    @(negedge clk);
    chk("d_redir_no_req", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    @(negedge clk);
    chk("d_drop_no_req",    64'(imem_req_valid), 64'd0);
    chk("d_drop_inst_vld",  64'(inst_valid),     64'd0);
    step();
    @(negedge clk);
    chk("d_new_req_valid",  64'(imem_req_valid), 64'd1);
    chk("d_new_req_addr",   imem_req_addr,       64'h8000_0100);
    chk("d_fifo_empty",     64'(inst_valid),     64'd0);
    step();
    imem_req_ready = 1'b0;
    drain(4);
    end_chk("d");

    // E: redirect in the same cycle as the response.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0200);
    exp_inst.push_back('{pc: 64'h8000_0200, w: 32'h0800_0093});
    do_reset("e", 1'b1, 1'b1);
    wait_acc("e_acc0", 2);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    chk("e_redir_no_req", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("e_new_req_valid", 64'(imem_req_valid), 64'd1);
    chk("e_new_req_addr",  imem_req_addr,       64'h8000_0200);
    chk("e_inst_vld",      64'(inst_valid),     64'd0);
    step();
    imem_req_ready = 1'b0;
    drain(4);
    end_chk("e");

    // F: reset while waiting; the late response must be ignored.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0000);
    exp_inst.push_back('{pc: 64'h8000_0000, w: 32'h0000_0093});
    mem_lat = 3;
    do_reset("f", 1'b1, 1'b1);
    wait_acc("f_acc0", 2);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("f_rst_req_valid",  64'(imem_req_valid), 64'd0);
    chk("f_rst_inst_valid", 64'(inst_valid),     64'd0);
    step();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("f_post_req_valid", 64'(imem_req_valid), 64'd1);
      chk("f_post_req_addr",  imem_req_addr,       64'h8000_0000);
      chk("f_late_ignored",   64'(inst_valid),     64'd0);
      step();
    end
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    wait_acc("f_acc1", 2);
    step();
    imem_req_ready = 1'b0;
    drain(4);
    end_chk("f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage directly upstream of the single-cycle core. Owns the fetch PC and issues 32-bit instruction reads to instruction memory over a valid/ready request channel with an unstalled response channel. Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready interface. Flushes and redirects on taken jumps/branches signalled by the core.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000: fetch PC after reset
- DEPTH, 2: instruction FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  byte address, always 4-aligned in operation
- imem_resp_valid  in  1  read data valid; one per accepted request, in order, ≥1 cycle after acceptance; never back-pressured
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  core consumes head
- inst  out  32  head instruction
- inst_pc  out  64  head PC
- redirect_valid  in  1  core requests refetch
- redirect_pc  in  64  new fetch PC

## Operation
- State: fpc (next fetch address), pend_pc (PC of outstanding request), FIFO of {pc, inst}, count, FSM {IDLE, WAIT, DROP}. At most one outstanding request.
- Issue: imem_req_valid=1, imem_req_addr=fpc when not rst, not redirect_valid, and either (IDLE and count<DEPTH) or (WAIT and imem_resp_valid and count+1−pop<DEPTH). pop = inst_valid & inst_ready.
- On acceptance (valid & ready): pend_pc<=fpc, fpc<=fpc+4 (64-bit wrap).
- Push: imem_resp_valid in WAIT without redirect writes {pend_pc, imem_resp_data} at tail. Issue rule guarantees a free slot.
- inst_valid = count!=0; inst/inst_pc = head. Simultaneous push and pop at any count is legal; count unchanged.
- FSM:
  - IDLE: redirect → IDLE; request accepted → WAIT; else IDLE.
  - WAIT: redirect & resp → IDLE; redirect & !resp → DROP; resp & request accepted → WAIT; resp otherwise → IDLE; else WAIT.
  - DROP: resp → IDLE (response discarded); else DROP.
- Redirect (any state): fpc<=redirect_pc, FIFO cleared (count<=0, pointers reset), no pop takes effect, no push, no request issued that cycle. Redirect while in DROP updates fpc, remains DROP. Consecutive redirects: last wins.
- Request stability: once imem_req_valid is raised, valid and addr hold until accepted, except it is withdrawn by redirect_valid or rst.
- Reset: fpc=RESET_PC, state IDLE, FIFO empty. Reset mid-request abandons it; a response arriving after reset with state IDLE is ignored.

## Timing
- All outputs registered or derived from registered state plus same-cycle handshake inputs; imem_req_valid also depends on imem_resp_valid, inst_ready, redirect_valid.
- During rst: imem_req_valid=0, inst_valid=0, inst/inst_pc=0 (FIFO storage cleared).
- First cycle after rst deasserts: imem_req_valid=1, addr=RESET_PC.
- Latency: response in cycle N → inst_valid in N+1. Redirect in cycle N → first request to redirect_pc in N+1 (IDLE) or after the dropped response (DROP).
- Peak throughput: one instruction per cycle with single-cycle memory and inst_ready held high.

## Configuration
- IFU_PERF_EN: when defined, adds outputs perf_fetch_cnt (64, pushes into FIFO) and perf_stall_cnt (64, cycles with inst_ready=1 and inst_valid=0), both reset to 0, wrap on overflow, not cleared by redirect. When undefined, ports and counters are absent.

## Structure
- Shared package: FSM state enum, RESET_PC default, instruction width 32 and address width 64 constants.
- Sub-module fetch_fifo: parameterised DEPTH, {pc,inst} payload, push/pop/flush, count/empty/full.

## Test plan
- Reset then single-cycle memory, inst_ready=1: requests 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; inst_pc sequence matches, one inst per cycle.
- inst_ready=0 with DEPTH=2: after two responses, imem_req_valid stays 0; raising inst_ready resumes fetch at 0x80000008.
- imem_req_ready low 3 cycles: imem_req_valid and addr 0x80000000 held stable throughout.
- Redirect to 0x80000100 while request to 0x80000004 outstanding: its response (0x00100093) dropped, FIFO empty, next request 0x80000100.
- Redirect in same cycle as response: response discarded, next cycle request to redirect_pc.
- rst asserted while in WAIT: late response ignored, first post-reset request at 0x80000000.
